dft_frame_loader: RTL and testbench
===================================

// Module: dft_frame_loader
// PURPOSE
//  Upstream feeder for the LLKI-wrapped DFT core. Accepts 64-bit sample words over a valid/ready
//  stream and buffers each full frame in a ping-pong (two-bank) store. Replays each frame to the
//  core as a one-cycle next pulse followed by FRAME_BEATS gap-free beats on X0..X3.
//  Lets a bursty bus master feed a core that requires continuous input once a frame starts.
// PARAMETERS
//  FRAME_BEATS     32  beats per DFT frame (2 complex samples/beat); power of 2, >=2
//  INTER_FRAME_GAP 0   minimum idle cycles between the last beat of a frame and the next pulse
// PORTS
//  clk        in   1   sole clock; all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   in_data holds a valid sample word
//  in_ready   out  1   loader can accept a word this cycle
//  in_data    in   64  {X3,X2,X1,X0}, 16 bits each; X0 = [15:0]
//  next       out  1   one-cycle frame-start pulse to the DFT core
//  X0..X3     out  16  per-beat sample lanes to the DFT core (registered)
//  busy       out  1   high while any bank is full or the read FSM is not in IDLE
//  frames_out out  16  [DFT_LOADER_STATS_EN only] frames launched, wraps at 0xFFFF
//  stall_cnt  out  16  [DFT_LOADER_STATS_EN only] cycles with in_valid && !in_ready, saturates
// BEHAVIOUR
//  Reset (async assert, sync release): wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, bank_full=2'b00,
//   FSM=IDLE. Outputs: in_ready=1, next=0, X0..X3=0, busy=0, counters=0.
//   Any partial or queued frame is discarded. Reset mid-stream aborts the frame immediately.
//  Write side:
//   - in_ready = !bank_full[wr_bank], combinational from registered state only.
//   - Handshake (in_valid && in_ready) writes bank[wr_bank][wr_cnt] and increments wr_cnt.
//   - At wr_cnt == FRAME_BEATS-1: set bank_full[wr_bank], toggle wr_bank, wrap wr_cnt to 0.
//   - No partial-frame flush; a frame launches only once complete.
//  Read FSM (IDLE -> START -> STREAM -> GAP -> IDLE):
//   - IDLE: if bank_full[rd_bank], go to START.
//   - START: next=1 for exactly this cycle; X0..X3 = 0.
//   - STREAM: rd_cnt runs 0..FRAME_BEATS-1, driving bank[rd_bank][rd_cnt] onto X0..X3 on every
//     cycle, with no stalls. After the last beat: clear bank_full[rd_bank], toggle rd_bank,
//     go to GAP (or straight to IDLE if INTER_FRAME_GAP==0). X0..X3 return to 0 outside STREAM.
//   - GAP: count INTER_FRAME_GAP cycles, then go to IDLE.
//  Latency: the word-complete handshake at cycle T sets bank_full at T+1, FSM enters START (next=1)
//   at T+2, and beat 0 appears at T+3. Each following frame starts no sooner than
//   1+INTER_FRAME_GAP cycles after the previous last beat (START re-entered via IDLE).
//  Boundaries:
//   - Both banks full: in_ready=0, and input stalls without losing data.
//   - A bank clearing while the writer waits on it: in_ready rises the cycle after the clear.
//   - Simultaneous write-complete on one bank and read-clear on the other: both take effect;
//     the banks are independent.
//   - wr_cnt and rd_cnt wrap modulo FRAME_BEATS. Beat order is preserved exactly, and frames
//     leave in arrival order.
// CONFIGURATION
//  DFT_LOADER_STATS_EN defined:
//   - frames_out increments in each START cycle.
//   - stall_cnt increments on each in_valid && !in_ready cycle and saturates at 0xFFFF.
//  DFT_LOADER_STATS_EN undefined: the frames_out and stall_cnt ports and their logic are absent.
//   All other behaviour is identical.
// TESTING
//  1. Reset: hold rst_n=0, drive in_valid=1 -> in_ready=1, next=0, X*=0, busy=0; no writes occur.
//  2. Single frame: 32 words with in_data={4{beat_idx[15:0]}} back-to-back -> next pulses 2 cycles
//     after the last handshake; X0..X3 = 0,1,..,31 on 32 consecutive cycles.
//  3. Backpressure: 96 words pushed continuously -> in_ready drops after word 64. It rises the cycle
//     after frame 0's last beat. All 3 frames stream intact and in order.
//  4. Gap: INTER_FRAME_GAP=4 with two full frames queued -> next pulses are 38 cycles apart
//     (1 START + 32 beats + 4 gap + 1 IDLE).
//  5. Reset mid-stream: assert rst_n=0 at beat 10 -> X*=0 and next=0 immediately. After release,
//     no stale beats appear and the next complete frame streams correctly.
//  6. STATS_EN: 3 frames with 5 stalled cycles -> frames_out=3, stall_cnt=5. Forcing 0xFFFF stalls
//     holds stall_cnt at 0xFFFF.

Source files
------------

// File: rtl/dft_frame_loader.sv
// Ping-pong frame buffer feeding the DFT core: frames stream out gap-free, three cycles after their last word.
// Optional statistics counters (frames_out, stall_cnt) exist only when DFT_LOADER_STATS_EN is defined.
module dft_frame_loader #(
  parameter int FRAME_BEATS     = 32,
  parameter int INTER_FRAME_GAP = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        next,
  output logic [15:0] X0,
  output logic [15:0] X1,
  output logic [15:0] X2,
  output logic [15:0] X3,
  output logic        busy
`ifdef DFT_LOADER_STATS_EN
  ,
  output logic [15:0] frames_out,
  output logic [15:0] stall_cnt
`endif
);

  localparam int CW = $clog2(FRAME_BEATS);
  localparam int GW = (INTER_FRAME_GAP > 1) ? $clog2(INTER_FRAME_GAP) : 1;

  typedef enum logic [1:0] {IDLE, START, STREAM, GAP} state_t;

  // Bank b occupies entries [b*FRAME_BEATS +: FRAME_BEATS]
  logic [63:0]   mem [2*FRAME_BEATS];

  logic          wr_bank;
  logic [CW-1:0] wr_cnt;
  logic          rd_bank;
  logic [CW-1:0] rd_cnt;
  logic [1:0]    bank_full;
  logic [GW-1:0] gap_cnt;
  state_t        state;
  state_t        state_nxt;

  logic          wr_fire;
  logic          wr_last;
  logic          rd_last;
  logic [1:0]    set_mask;
  logic [1:0]    clr_mask;
  logic          load;
  logic [CW:0]   rd_addr;
  logic [63:0]   rd_word;

  assign in_ready = !bank_full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign wr_last  = wr_fire && (wr_cnt == CW'(FRAME_BEATS - 1));
  assign rd_last  = (state == STREAM) && (rd_cnt == CW'(FRAME_BEATS - 1));
  assign busy     = (|bank_full) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank, wr_cnt}] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + CW'(1);
      if (wr_last) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // The writer and reader never target the same bank in one cycle, so set and clear cannot collide.
  always_comb begin
    set_mask = 2'b00;
    clr_mask = 2'b00;
    if (wr_last) begin
      set_mask = 2'b01 << wr_bank;
    end
    if (rd_last) begin
      clr_mask = 2'b01 << rd_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full & ~clr_mask) | set_mask;
    end
  end

  always_comb begin
    state_nxt = state;
    next      = 1'b0;
    case (state)
      IDLE: begin
        if (bank_full[rd_bank]) begin
          state_nxt = START;
        end
      end
      START: begin
        next      = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        if (rd_last) begin
          state_nxt = (INTER_FRAME_GAP == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(INTER_FRAME_GAP - 1)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The lane registers are loaded one cycle ahead: START preloads beat 0, each STREAM beat k preloads k+1.
  always_comb begin
    load    = (state == START) || ((state == STREAM) && !rd_last);
    rd_addr = (state == START) ? {rd_bank, {CW{1'b0}}} : {rd_bank, rd_cnt + CW'(1)};
  end

  assign rd_word = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      gap_cnt <= '0;
      X0      <= 16'd0;
      X1      <= 16'd0;
      X2      <= 16'd0;
      X3      <= 16'd0;
    end else begin
      state <= state_nxt;
      if (state == STREAM) begin
        rd_cnt <= rd_cnt + CW'(1);
      end
      if (rd_last) begin
        rd_bank <= ~rd_bank;
      end
      if (state == GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
      end else begin
        gap_cnt <= '0;
      end
      if (load) begin
        X0 <= rd_word[15:0];
        X1 <= rd_word[31:16];
        X2 <= rd_word[47:32];
        X3 <= rd_word[63:48];
      end else begin
        X0 <= 16'd0;
        X1 <= 16'd0;
        X2 <= 16'd0;
        X3 <= 16'd0;
      end
    end
  end

`ifdef DFT_LOADER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_out <= 16'd0;
      stall_cnt  <= 16'd0;
    end else begin
      if (state == START) begin
        frames_out <= frames_out + 16'd1;
      end
      if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dft_frame_loader.sv
// Directed bench for dft_frame_loader: a scoreboard of accepted words checks every streamed beat.
module tb_dft_frame_loader;
  localparam int FB = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready, next, busy;
  logic [15:0] X0, X1, X2, X3;
  logic        g_in_ready, g_next, g_busy;
  logic [15:0] g_X0, g_X1, g_X2, g_X3;
`ifdef DFT_LOADER_STATS_EN
  logic [15:0] frames_out, stall_cnt, g_frames_out, g_stall_cnt;
`endif

  always #5 clk = ~clk;

  dft_frame_loader #(.FRAME_BEATS(FB), .INTER_FRAME_GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .next(next), .X0(X0), .X1(X1), .X2(X2), .X3(X3), .busy(busy)
`ifdef DFT_LOADER_STATS_EN
    , .frames_out(frames_out), .stall_cnt(stall_cnt)
`endif
  );

  dft_frame_loader #(.FRAME_BEATS(FB), .INTER_FRAME_GAP(4)) dut_gap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(g_in_ready), .in_data(in_data),
    .next(g_next), .X0(g_X0), .X1(g_X1), .X2(g_X2), .X3(g_X3), .busy(g_busy)
`ifdef DFT_LOADER_STATS_EN
    , .frames_out(g_frames_out), .stall_cnt(g_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] exp_q[$];
  int beat_rem = 0, mon_frames = 0, mon_nexts = 0;
  int last_next_cyc = 0, prev_next_cyc = 0, frame0_last_cyc = -1;
  int g_nexts = 0, g_last = 0, g_prev = 0;
  int last_hs_cyc = 0, stall_cycles = 0, first_stall_word = 0, ready_rise_cyc = -1, word_idx = 0;
  bit stalled_any = 1'b0;

  typedef struct {
    int          n_words;
    int          idle_every;
    logic [15:0] base;
    int          exp_frames;
    int          exp_left;
    bit          exp_stall;
  } vec_t;
  vec_t vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkw(input logic [15:0] b, input int i);
    logic [15:0] v;
    v = b + 16'(4 * i);
    return {v + 16'd3, v + 16'd2, v + 16'd1, v};
  endfunction

  // Beat monitor: after each next pulse expect FB consecutive beats matching accepted words in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (next) begin
        chk("next_inside_frame", 64'(beat_rem), 64'd0);
        chk("lanes_at_start", {X3, X2, X1, X0}, 64'd0);
        mon_nexts++;
        prev_next_cyc = last_next_cyc;
        last_next_cyc = cyc;
        beat_rem = FB;
      end else if (beat_rem > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_without_word: got %0h, expected no beat", {X3, X2, X1, X0});
        end else begin
          chk("beat_data", {X3, X2, X1, X0}, exp_q.pop_front());
        end
        beat_rem--;
        if (beat_rem == 0) begin
          if (mon_frames == 0) frame0_last_cyc = cyc;
          mon_frames++;
        end
      end else begin
        chk("lanes_idle", {X3, X2, X1, X0}, 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && g_next) begin
      g_prev = g_last;
      g_last = cyc;
      g_nexts++;
    end
  end

  task automatic clear_vars();
    exp_q.delete();
    beat_rem = 0; mon_frames = 0; mon_nexts = 0;
    last_next_cyc = 0; prev_next_cyc = 0; frame0_last_cyc = -1;
    g_nexts = 0; g_last = 0; g_prev = 0;
    last_hs_cyc = 0; stall_cycles = 0; first_stall_word = 0; ready_rise_cyc = -1; word_idx = 0;
    stalled_any = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_vars();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [63:0] w);
    bit hs = 1'b0;
    bit was_low = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_data = w;
    word_idx++;
    while (!hs && n < 3000) begin
      @(negedge clk);
      hs = in_ready;
      if (!in_ready) begin
        stall_cycles++;
        was_low = 1'b1;
        if (!stalled_any) begin
          stalled_any = 1'b1;
          first_stall_word = word_idx;
        end
      end else if (was_low && ready_rise_cyc < 0) begin
        ready_rise_cyc = cyc;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: word %0d not accepted, in_ready=%0b, required 1", word_idx, in_ready);
    end else begin
      exp_q.push_back(w);
      last_hs_cyc = cyc - 1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || g_busy || beat_rem != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: busy=%0b beats_left=%0d, required idle", busy, beat_rem);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{n_words: 32,  idle_every: 0, base: 16'h0100, exp_frames: 1, exp_left: 0, exp_stall: 1'b0};
    vecs[1] = '{n_words: 40,  idle_every: 3, base: 16'hA000, exp_frames: 1, exp_left: 8, exp_stall: 1'b0};
    vecs[2] = '{n_words: 64,  idle_every: 1, base: 16'h2000, exp_frames: 2, exp_left: 0, exp_stall: 1'b0};
    vecs[3] = '{n_words: 128, idle_every: 0, base: 16'hF000, exp_frames: 4, exp_left: 0, exp_stall: 1'b1};
    vecs[4] = '{n_words: 33,  idle_every: 0, base: 16'h5550, exp_frames: 1, exp_left: 1, exp_stall: 1'b0};

    // Reset held with a valid word offered: nothing may be accepted or emitted.
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 64'hDEAD_BEEF_CAFE_F00D;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_next", 64'(next), 64'd0);
    chk("reset_lanes", {X3, X2, X1, X0}, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    clear_vars();
    rst_n = 1'b1;

    // Single frame, lanes carry the beat index.
    for (int i = 0; i < FB; i++) push({4{16'(i)}});
    wait_idle();
    chk("single_next_latency", 64'(last_next_cyc - last_hs_cyc), 64'd2);
    chk("single_frames", 64'(mon_frames), 64'd1);
    chk("single_leftover", 64'(exp_q.size()), 64'd0);

    // Table-driven streams: counts, gaps and partial tails.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n_words; i++) begin
        push(mkw(vecs[v].base, i));
        if (vecs[v].idle_every > 0 && (i % vecs[v].idle_every) == vecs[v].idle_every - 1) begin
          @(posedge clk);
          #1;
        end
      end
      wait_idle();
      chk($sformatf("vec%0d_frames", v), 64'(mon_frames), 64'(vecs[v].exp_frames));
      chk($sformatf("vec%0d_leftover", v), 64'(exp_q.size()), 64'(vecs[v].exp_left));
      chk($sformatf("vec%0d_stalled", v), 64'(stalled_any), 64'(vecs[v].exp_stall));
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
      chk($sformatf("vec%0d_in_ready", v), 64'(in_ready), 64'd1);
    end

    // Backpressure: 96 words pushed continuously.
    do_reset();
    for (int i = 0; i < 96; i++) push(mkw(16'h4000, i));
    wait_idle();
    chk("bp_first_stalled_word", 64'(first_stall_word), 64'd65);
    chk("bp_stall_cycles", 64'(stall_cycles), 64'd2);
    chk("bp_ready_rise", 64'(ready_rise_cyc), 64'(frame0_last_cyc + 1));
    chk("bp_frames", 64'(mon_frames), 64'd3);
    chk("bp_leftover", 64'(exp_q.size()), 64'd0);
`ifdef DFT_LOADER_STATS_EN
    chk("stats_frames_out", 64'(frames_out), 64'd3);
    chk("stats_stall_cnt", 64'(stall_cnt), 64'd2);
`endif

    // Two queued frames: spacing of next pulses with and without the inter-frame gap.
    do_reset();
    for (int i = 0; i < 2 * FB; i++) push(mkw(16'h3000, i));
    wait_idle();
    chk("gap0_nexts", 64'(mon_nexts), 64'd2);
    chk("gap0_spacing", 64'(last_next_cyc - prev_next_cyc), 64'd34);
    chk("gap4_nexts", 64'(g_nexts), 64'd2);
    chk("gap4_spacing", 64'(g_last - g_prev), 64'd38);

    // Reset asserted during beat 10 of a frame.
    do_reset();
    for (int i = 0; i < FB; i++) push(mkw(16'h7000, i));
    for (int n = 0; n < 100 && mon_nexts == 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("midrst_started", 64'(mon_nexts), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_beat10", {X3, X2, X1, X0}, mkw(16'h7000, 10));
    rst_n = 1'b0;
    #1;
    chk("midrst_lanes", {X3, X2, X1, X0}, 64'd0);
    chk("midrst_next", 64'(next), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    clear_vars();
    rst_n = 1'b1;
    for (int i = 0; i < FB; i++) push(mkw(16'h9000, i));
    wait_idle();
    chk("midrst_nexts_after", 64'(mon_nexts), 64'd1);
    chk("midrst_frames_after", 64'(mon_frames), 64'd1);
    chk("midrst_leftover", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
